// File: rtl/l2_assoc_cache.sv
// l2_assoc_cache: N-way set-associative write-back/write-allocate cache, one word per line, true-LRU.
module l2_assoc_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4,
    parameter int WAYS       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;
    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int AW       = $clog2(WAYS);

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESP} state_t;
    state_t state, state_n;

    logic                  valid_q [SETS][WAYS];
    logic                  dirty_q [SETS][WAYS];
    logic [TAG_BITS-1:0]   tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
    logic [AW-1:0]         age_q   [SETS][WAYS];

    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_wr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [AW-1:0]         vw, hw, inv_w, lru_w, victim, ins_way;
    logic                  hit, inv_any, vdirty, accept, ins, upd;
    logic [DATA_WIDTH-1:0] ins_data;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;

    assign idx       = a_addr[INDEX_BITS-1:0];
    assign tag       = a_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign req_ready = rst_n && (state == IDLE || state == RESP);
    assign resp_valid = state == RESP;
    assign accept    = req_valid && req_ready;

    // Downward scan so the lowest-numbered invalid way wins.
    always_comb begin
        hit = 1'b0;
        hw = '0;
        inv_any = 1'b0;
        inv_w = '0;
        lru_w = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit = 1'b1;
                hw = AW'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_any = 1'b1;
                inv_w = AW'(w);
            end
            if (age_q[idx][w] == AW'(WAYS - 1)) lru_w = AW'(w);
        end
    end

    assign victim   = inv_any ? inv_w : lru_w;
    assign vdirty   = valid_q[idx][victim] && dirty_q[idx][victim];
    assign ins      = (state == LOOKUP && a_wr && (hit || !vdirty)) ||
                      (state == EVICT && mem_ready && a_wr) || (state == FILL && mem_ready);
    assign upd      = ins || (state == LOOKUP && hit);
    assign ins_way  = state == LOOKUP ? (hit ? hw : victim) : vw;
    assign ins_data = state == FILL ? mem_rdata : a_wdata;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? LOOKUP : IDLE;
            LOOKUP:  state_n = hit ? RESP : vdirty ? EVICT : a_wr ? RESP : FILL;
            EVICT:   state_n = mem_ready ? (a_wr ? RESP : FILL) : EVICT;
            FILL:    state_n = mem_ready ? RESP : FILL;
            RESP:    state_n = accept ? LOOKUP : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (ins) begin
            tag_q[idx][ins_way]  <= tag;
            data_q[idx][ins_way] <= ins_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= AW'(w);
                end
        end else begin
            if (ins) begin
                valid_q[idx][ins_way] <= 1'b1;
                dirty_q[idx][ins_way] <= state != FILL;
            end
            if (upd)
                for (int w = 0; w < WAYS; w++)
                    age_q[idx][w] <= AW'(w) == ins_way ? '0 :
                        age_q[idx][w] + AW'(age_q[idx][w] < age_q[idx][ins_way]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_addr     <= '0;
            a_wr       <= 1'b0;
            a_wdata    <= '0;
            vw         <= '0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            mem_valid  <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if (accept) begin
                a_addr  <= req_addr;
                a_wr    <= req_wr;
                a_wdata <= req_wdata;
            end
            if (state == LOOKUP) vw <= victim;
            if (state != RESP && state_n == RESP) begin
                resp_hit   <= state == LOOKUP && hit;
                resp_rdata <= (state == LOOKUP && hit && !a_wr) ? data_q[idx][hw] : ins_data;
            end
            // A dirty victim goes out first; a read then chains straight into its fill.
            if (state == LOOKUP && !hit && (vdirty || !a_wr)) begin
                mem_valid <= 1'b1;
                mem_wr    <= vdirty;
                mem_addr  <= vdirty ? {tag_q[idx][victim], idx} : a_addr;
                mem_wdata <= data_q[idx][victim];
            end else if (mem_valid && mem_ready) begin
                mem_valid <= state == EVICT && !a_wr;
                mem_wr    <= 1'b0;
                mem_addr  <= a_addr;
            end
        end
    end
endmodule

// File: tb/tb_l2_assoc_cache.sv
// tb_l2_assoc_cache: random and directed traffic checked against an MRU-ordered list model of each set.
module tb_l2_assoc_cache;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_hit;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    l2_assoc_cache dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {bit wr; logic [31:0] addr; logic [31:0] data;} mem_t;
    typedef struct {bit hit; logic [31:0] data; bit nomem;} rsp_t;
    typedef struct {bit wr; logic [31:0] addr; logic [31:0] data; int len;} seen_t;

    int checks = 0, errors = 0;
    mem_t  exp_mem[$];
    rsp_t  exp_resp[$];
    seen_t log_q[$];
    logic [31:0] mem[logic [31:0]];

    // Set contents, position 0 = MRU.
    logic [31:0] m_addr[16][4], m_data[16][4];
    bit          m_dirty[16][4];
    int          m_cnt[16];

    time  t_acc;
    bit   last_hit;
    logic [31:0] last_rdata;
    time  last_lat;
    int   fixed_dly = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic void model(bit wr, logic [31:0] a, logic [31:0] d);
        int s, hi, nm0;
        logic [31:0] ld;
        bit ldirty, h;
        s = int'(a[3:0]);
        hi = -1;
        nm0 = exp_mem.size();
        for (int i = 0; i < m_cnt[s]; i++) if (m_addr[s][i] == a) hi = i;
        if (hi >= 0) begin
            h = 1'b1;
            ld = wr ? d : m_data[s][hi];
            ldirty = m_dirty[s][hi] | wr;
            for (int j = hi; j < m_cnt[s] - 1; j++) begin
                m_addr[s][j] = m_addr[s][j+1];
                m_data[s][j] = m_data[s][j+1];
                m_dirty[s][j] = m_dirty[s][j+1];
            end
            m_cnt[s]--;
        end else begin
            h = 1'b0;
            if (m_cnt[s] == 4) begin
                if (m_dirty[s][3]) exp_mem.push_back(mem_t'{1'b1, m_addr[s][3], m_data[s][3]});
                m_cnt[s] = 3;
            end
            if (wr) begin
                ld = d;
                ldirty = 1'b1;
            end else begin
                exp_mem.push_back(mem_t'{1'b0, a, 32'h0});
                ld = mem_rd(a);
                ldirty = 1'b0;
            end
        end
        for (int j = m_cnt[s]; j > 0; j--) begin
            m_addr[s][j] = m_addr[s][j-1];
            m_data[s][j] = m_data[s][j-1];
            m_dirty[s][j] = m_dirty[s][j-1];
        end
        m_addr[s][0] = a;
        m_data[s][0] = ld;
        m_dirty[s][0] = ldirty;
        m_cnt[s]++;
        exp_resp.push_back(rsp_t'{h, ld, exp_mem.size() == nm0});
    endfunction

    // Compare process and memory responder, all on the falling edge.
    int   wcnt = 0, dly = 0;
    bit   prev_resp = 1'b0;
    logic h_wr;
    logic [31:0] h_addr, h_wdata;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            wcnt = 0;
            prev_resp = 1'b0;
        end else begin
            mem_ready = 1'b0;
            if (resp_valid) begin
                chk("resp_one_cycle", prev_resp, 0);
                chk("resp_expected", exp_resp.size() > 0, 1);
                if (exp_resp.size() > 0) begin
                    rsp_t e;
                    e = exp_resp.pop_front();
                    chk("resp_hit", resp_hit, e.hit);
                    chk("resp_rdata", resp_rdata, e.data);
                    last_hit = resp_hit;
                    last_rdata = resp_rdata;
                    last_lat = $time - t_acc;
                    if (e.nomem) chk("nomem_latency", last_lat, 15);
                end
            end
            prev_resp = resp_valid;
            if (mem_valid) begin
                chk("req_ready_busy", req_ready, 0);
                if (wcnt == 0) begin
                    h_wr = mem_wr;
                    h_addr = mem_addr;
                    h_wdata = mem_wdata;
                    dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
                end else begin
                    chk("mem_wr_stable", mem_wr, h_wr);
                    chk("mem_addr_stable", mem_addr, h_addr);
                    if (h_wr) chk("mem_wdata_stable", mem_wdata, h_wdata);
                end
                if (wcnt >= dly) begin
                    mem_ready = 1'b1;
                    log_q.push_back(seen_t'{mem_wr, mem_addr, mem_wdata, wcnt + 1});
                    chk("mem_expected", exp_mem.size() > 0, 1);
                    if (exp_mem.size() > 0) begin
                        mem_t m;
                        m = exp_mem.pop_front();
                        chk("mem_wr", mem_wr, m.wr);
                        chk("mem_addr", mem_addr, m.addr);
                        if (m.wr) chk("mem_wdata", mem_wdata, m.data);
                    end
                    if (mem_wr) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem_rd(mem_addr);
                    wcnt = 0;
                end else wcnt++;
            end else if (wcnt > 0) begin
                chk("mem_retract", mem_valid, 1);
                wcnt = 0;
            end
        end
    end

    task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int n;
        req_valid = 1'b1;
        req_wr = wr;
        req_addr = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        model(wr, a, d);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 300);
        if (!resp_valid) chk("resp_timeout", resp_valid, 1);
        #1;
    endtask

    initial begin
        int n0, n;
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int s = 0; s < 16; s++) m_cnt[s] = 0;
        mem[32'h10] = 32'hDEADBEEF;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        #1 chk("post_rst_ready", req_ready, 1);

        fixed_dly = 2;
        n0 = log_q.size();
        req(1'b0, 32'h10, 0);
        chk("cold_hit", last_hit, 0);
        chk("cold_data", last_rdata, 32'hDEADBEEF);
        chk("cold_mem_count", log_q.size() - n0, 1);
        chk("cold_mem_wr", log_q[n0].wr, 0);
        chk("cold_mem_addr", log_q[n0].addr, 32'h10);
        chk("cold_mem_len", log_q[n0].len, 3);
        n0 = log_q.size();
        req(1'b0, 32'h10, 0);
        chk("reread_hit", last_hit, 1);
        chk("reread_data", last_rdata, 32'hDEADBEEF);
        chk("reread_mem_count", log_q.size() - n0, 0);
        chk("reread_latency", last_lat, 15);
        fixed_dly = -1;

        req(1'b1, 32'h10, 32'h11111111);
        chk("wr_hit", last_hit, 1);
        req(1'b0, 32'h20, 0);
        req(1'b0, 32'h30, 0);
        req(1'b0, 32'h40, 0);
        n0 = log_q.size();
        req(1'b0, 32'h50, 0);
        chk("evict_count", log_q.size() - n0, 2);
        chk("evict_wr", log_q[n0].wr, 1);
        chk("evict_addr", log_q[n0].addr, 32'h10);
        chk("evict_data", log_q[n0].data, 32'h11111111);
        chk("evict_fill_wr", log_q[n0+1].wr, 0);
        chk("evict_fill_addr", log_q[n0+1].addr, 32'h50);

        req(1'b0, 32'h20, 0);
        chk("lru_touch_hit", last_hit, 1);
        n0 = log_q.size();
        req(1'b0, 32'h60, 0);
        chk("lru_mem_count", log_q.size() - n0, 1);
        chk("lru_fill_wr", log_q[n0].wr, 0);
        chk("lru_fill_addr", log_q[n0].addr, 32'h60);
        req(1'b0, 32'h20, 0);
        chk("lru_keep_20", last_hit, 1);
        req(1'b0, 32'h30, 0);
        chk("lru_gone_30", last_hit, 0);

        n0 = log_q.size();
        req(1'b1, 32'h25, 32'h0000A5A5);
        chk("wmiss_mem_count", log_q.size() - n0, 0);
        chk("wmiss_hit", last_hit, 0);
        chk("wmiss_data", last_rdata, 32'h0000A5A5);
        req(1'b0, 32'h25, 0);
        chk("wmiss_reread_hit", last_hit, 1);
        chk("wmiss_reread_data", last_rdata, 32'h0000A5A5);

        for (int k = 0; k < 4; k++) req(1'b1, 32'(k * 16 + 6), 32'(32'h600 + k));
        fixed_dly = 10;
        n0 = log_q.size();
        req(1'b0, 32'h46, 0);
        chk("hold_mem_count", log_q.size() - n0, 2);
        chk("hold_wb_wr", log_q[n0].wr, 1);
        chk("hold_wb_addr", log_q[n0].addr, 32'h06);
        chk("hold_wb_data", log_q[n0].data, 32'h600);
        chk("hold_wb_len", log_q[n0].len, 11);
        chk("hold_fill_wr", log_q[n0+1].wr, 0);

        fixed_dly = 30;
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_addr = 32'h77;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        t_acc = $time;
        model(1'b0, 32'h77, 0);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_valid && n < 50);
        chk("fill_started", mem_valid, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_mem_valid", mem_valid, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        for (int s = 0; s < 16; s++) m_cnt[s] = 0;
        exp_mem.delete();
        exp_resp.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        fixed_dly = -1;
        @(negedge clk);
        #1 chk("midrst_release_ready", req_ready, 1);
        n0 = log_q.size();
        req(1'b0, 32'h77, 0);
        chk("midrst_reread_hit", last_hit, 0);
        chk("midrst_reread_mem", log_q.size() - n0, 1);
        req(1'b0, 32'h36, 0);
        chk("lost_dirty_hit", last_hit, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) << 4) | $urandom_range(0, 3);
            req($urandom_range(0, 9) < 4, a, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("resp_drained", exp_resp.size(), 0);
        chk("mem_drained", exp_mem.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_assoc_cache.md
Name: l2_assoc_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate L2 cache with true-LRU replacement. It has a valid/ready request port toward the core side and a blocking single-word memory port toward the backing store. There is one line per (set, way), and each line holds one data word. At most one request is in flight at a time. The block is the next-generation replacement for the fixed 2/4-way, write-through L2.

Parameters:
ADDR_WIDTH, 32, word address width
DATA_WIDTH, 32, data word width
INDEX_BITS, 4, set index width; sets = 2**INDEX_BITS
WAYS, 4, associativity; power of two, >= 2
TAG_BITS is derived, not overridable: ADDR_WIDTH-INDEX_BITS.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  cache can accept a request
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  word address; index=[INDEX_BITS-1:0], tag=[ADDR_WIDTH-1:INDEX_BITS]
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  one-cycle response strobe; no backpressure
resp_hit  out  1  1=hit, 0=miss (qualified by resp_valid)
resp_rdata  out  DATA_WIDTH  read data; for a write, the written data
mem_valid  out  1  memory request
mem_ready  in  1  memory accepts write / returns read data this cycle
mem_wr  out  1  1=write-back, 0=fill read
mem_addr  out  ADDR_WIDTH  memory word address
mem_wdata  out  DATA_WIDTH  write-back data
mem_rdata  in  DATA_WIDTH  fill data, valid when mem_valid & mem_ready & !mem_wr

Behaviour:
- Reset (rst_n low, asynchronous): all valid and dirty bits are cleared. Age of way w = w. FSM goes to IDLE. req_ready, resp_valid, resp_hit and mem_valid are 0; resp_rdata, mem_addr and mem_wdata are 0. req_ready is held 0 while rst_n is low.
- Line state: valid, dirty, tag and data per (set, way). Age per (set, way) is log2(WAYS) bits; 0=MRU, WAYS-1=LRU. The ages within a set are always a permutation of 0..WAYS-1.
- FSM states: IDLE, LOOKUP, EVICT, FILL, RESP.
- IDLE: req_ready=1. Acceptance is req_valid & req_ready at a clock edge; at that edge addr, wr and wdata are latched and the FSM goes to LOOKUP. Request inputs are ignored in every other state.
- LOOKUP (exactly 1 cycle): the latched tag is compared against all valid ways of the set.
  - Read hit: resp_rdata=line data; go to RESP with hit=1.
  - Write hit: line data=wdata, dirty=1; go to RESP with hit=1.
  - Miss, victim selection: the lowest-numbered invalid way; otherwise the way with age WAYS-1.
  - Miss with a dirty victim: go to EVICT.
  - Miss, clean or invalid victim, read: go to FILL.
  - Miss, clean or invalid victim, write: install {valid=1, dirty=1, tag, wdata}; go to RESP with hit=0. There is no fill, because a line is one word.
- EVICT: mem_valid=1, mem_wr=1, mem_addr={victim tag, index}, mem_wdata=victim data. These are held stable until mem_ready.
  - On mem_ready, read request: go to FILL.
  - On mem_ready, write request: install as for a write miss, then go to RESP with hit=0.
- FILL: mem_valid=1, mem_wr=0, mem_addr=latched addr, held until mem_ready. On mem_ready: install {1, dirty=0, tag, mem_rdata}, resp_rdata=mem_rdata, go to RESP with hit=0.
- mem_valid is never retracted before mem_ready; mem_* outputs are registered and stable while waiting.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_hit and resp_rdata stay stable until the next response.
- LRU update on every hit and every install to way w:
  - Ways with age < age[w] increment.
  - age[w] becomes 0.
  - Other ways are unchanged.
- Latency, hit: accept at edge E0, LOOKUP cycle, resp_valid high in the cycle after edge E1 (2 cycles). The next request can be accepted at the edge that ends RESP.
- Latency, miss: 2 cycles + memory wait for FILL, +1 transaction for EVICT.
- Reset mid-operation: an in-flight request is dropped, dirty data is lost, and mem_valid falls asynchronously.

Test Plan:
Common setup: WAYS=4, INDEX_BITS=4.
- Cold read 0x10 with mem_ready after 3 cycles and mem_rdata=0xDEADBEEF. Required: mem_valid with mem_wr=0 and addr 0x10, held 3 cycles; resp hit=0 with data 0xDEADBEEF. Re-read 0x10: hit=1, data 0xDEADBEEF, no mem_valid, resp_valid exactly 2 cycles after acceptance.
- Write 0x10=0x11111111 after the fill, then read 0x20, 0x30, 0x40, 0x50 (all set 0). Required: 0x50 evicts 0x10, giving a mem write of addr 0x10 with data 0x11111111, then a fill read of 0x50.
- Fill set 0 clean with 0x20, 0x30, 0x40, 0x50, then read 0x20 (hit), then read 0x60. Required: the victim is 0x30's way, with no mem write. Then read 0x20 -> hit=1 and read 0x30 -> hit=0.
- Write miss 0x25=0x0000A5A5 into an empty set. Required: no mem_valid, resp hit=0, rdata 0x0000A5A5. Read 0x25 -> hit=1, data 0x0000A5A5.
- Hold mem_ready low 10 cycles during EVICT. Required: mem_addr and mem_wdata stable, req_ready=0 throughout, and exactly one write-back on mem_ready.
- Drive rst_n low while in FILL with mem_valid=1. Required: mem_valid=0, resp_valid=0 and req_ready=0 immediately. After release, req_ready=1, and a read of the same address misses.
